// File: rtl/mult_control_unit_if.sv
// Signal bundle between the multiplier controller and its surroundings:
// operator inputs, the external add/subtract stage, and the visible registers.
interface mult_control_unit_if;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] S;
    logic [8:0] Sum;
    logic [7:0] Add_A;
    logic [7:0] Add_B;
    logic       Sub;
    logic       Hold;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
    logic       Done;

    // Controller side.
    modport slave (
        input  Run, ClearA_LoadB, S, Sum,
        output Add_A, Add_B, Sub, Hold, Aval, Bval, X, Done
    );

    // Environment side: operator stimulus plus the adder feeding Sum back.
    modport master (
        output Run, ClearA_LoadB, S, Sum,
        input  Add_A, Add_B, Sub, Hold, Aval, Bval, X, Done
    );
endinterface

// File: rtl/mult_control_unit.sv
// Shift-and-add controller for an 8x8 signed multiply. {X,A} is the
// sign-extended partial product, B shifts out multiplier bits and shifts in
// product bits, M holds the multiplicand. The final step subtracts M because
// the multiplier's top bit carries negative weight in two's complement.
module mult_control_unit (
    input  logic                 Clk,
    input  logic                 Reset_n,
    mult_control_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] m_q, m_d;
    logic       x_q, x_d;
    logic [2:0] cnt_q, cnt_d;

    // State and datapath registers; an abort via reset clears every register.
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from values sampled before the edge; M is reset too, so no
    // stale multiplicand survives an aborted operation.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            m_q     <= 8'h00;
            x_q     <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update for each step of the multiply sequence.
    // NOTE: every _d gets its hold value first, so no path leaves a signal
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        x_d     = x_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                // Loading B wins over starting when both are requested.
                if (bus.ClearA_LoadB) begin
                    b_d = bus.S;
                    a_d = 8'h00;
                    x_d = 1'b0;
                end else if (bus.Run) begin
                    state_d = START;
                end
            end
            START: begin
                m_d     = bus.S;
                a_d     = 8'h00;
                x_d     = 1'b0;
                cnt_d   = 3'd0;
                state_d = ADD;
            end
            ADD: begin
                if (b_q[0]) begin
                    a_d = bus.Sum[7:0];
                    x_d = bus.Sum[8];
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d     = {x_q, a_q[7:1]};
                b_d     = {a_q[0], b_q[7:1]};
                cnt_d   = cnt_q + 3'd1;
                state_d = (cnt_q == 3'd7) ? DONE : ADD;
            end
            DONE: begin
                if (bus.ClearA_LoadB) begin
                    b_d = bus.S;
                    a_d = 8'h00;
                    x_d = 1'b0;
                end
                // A level-held Run must be released before another start.
                if (!bus.Run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register outputs and state decodes; none has a path from an input.
    assign bus.Add_A = a_q;
    assign bus.Add_B = m_q;
    assign bus.Aval  = a_q;
    assign bus.Bval  = b_q;
    assign bus.X     = x_q;
    assign bus.Done  = (state_q == DONE);
    assign bus.Sub   = (state_q == ADD) && (cnt_q == 3'd7);
    assign bus.Hold  = !((state_q == ADD) && b_q[0]);

endmodule

// File: tb/tb_mult_control_unit.sv
// Self-checking bench for mult_control_unit: a stimulus process queues the
// expected signed product for each Run, a monitor pops and compares when Done
// rises, and a small adder model closes the Sum loop.
module tb_mult_control_unit;

    logic clk;
    logic rst_n;

    mult_control_unit_if bus ();

    mult_control_unit dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 9-bit add/subtract stage; Hold zeroes both operands.
    logic [8:0] add_a9, add_b9;
    assign add_a9  = {bus.Add_A[7], bus.Add_A};
    assign add_b9  = {bus.Add_B[7], bus.Add_B};
    assign bus.Sum = bus.Hold ? 9'd0 : (bus.Sub ? add_a9 - add_b9 : add_a9 + add_b9);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       x;
        int         ones;
        int         done_cyc;
    } exp_t;

    exp_t exp_q[$];

    // Reference: plain signed arithmetic on the operands.
    function automatic exp_t model(input logic [7:0] m, input logic [7:0] b, input int dc);
        exp_t        e;
        int          p;
        logic [31:0] pv;
        p  = int'($signed(m)) * int'($signed(b));
        pv = p;
        e.a        = pv[15:8];
        e.b        = pv[7:0];
        e.x        = pv[15];
        e.ones     = $countones(b);
        e.done_cyc = dc;
        return e;
    endfunction

    // Monitor: count Sub/active-add cycles per operation, compare on Done rise.
    int   sub_seen  = 0;
    int   hold_low  = 0;
    logic done_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sub_seen  = 0;
                hold_low  = 0;
                done_prev = 1'b0;
            end else begin
                if (bus.Sub)   sub_seen++;
                if (!bus.Hold) hold_low++;
                if (bus.Done && !done_prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("result_aval", {24'd0, bus.Aval}, {24'd0, e.a});
                        check("result_bval", {24'd0, bus.Bval}, {24'd0, e.b});
                        check("result_x",    {31'd0, bus.X},    {31'd0, e.x});
                        check("sub_once",    sub_seen,          32'd1);
                        check("add_cycles",  hold_low,          e.ones);
                        check("latency",     cyc,               e.done_cyc);
                    end
                    sub_seen = 0;
                    hold_low = 0;
                end
                done_prev = bus.Done;
            end
        end
    end

    logic [7:0] b_shadow;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_b(input logic [7:0] v);
        bus.S            = v;
        bus.ClearA_LoadB = 1'b1;
        tick(1);
        bus.ClearA_LoadB = 1'b0;
        b_shadow         = v;
    endtask

    // One multiply: queue expectation, disturb S/ClearA_LoadB mid-run, wait
    // for Done (bounded), optionally reload B while parked in DONE, release Run.
    task automatic run_op(input logic [7:0] mval, input int hold_extra, input bit load_in_done);
        exp_t e;
        int   t;
        bus.S            = mval;
        bus.Run          = 1'b1;
        bus.ClearA_LoadB = 1'b0;
        e = model(mval, b_shadow, cyc + 18);
        exp_q.push_back(e);
        b_shadow = e.b;
        tick(2);
        t = 0;
        while (!bus.Done && t < 40) begin
            bus.S            = 8'($urandom);
            bus.ClearA_LoadB = 1'($urandom_range(0, 1));
            tick(1);
            t++;
        end
        bus.ClearA_LoadB = 1'b0;
        if (!bus.Done) begin
            check("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
        for (int i = 0; i < hold_extra; i++) begin
            tick(1);
            check("done_held", {31'd0, bus.Done}, 32'd1);
        end
        if (load_in_done) begin
            bus.S            = 8'hA5;
            bus.ClearA_LoadB = 1'b1;
            tick(1);
            bus.ClearA_LoadB = 1'b0;
            b_shadow         = 8'hA5;
            check("done_load_aval", {24'd0, bus.Aval}, 32'h00);
            check("done_load_bval", {24'd0, bus.Bval}, 32'hA5);
            check("done_load_x",    {31'd0, bus.X},    32'd0);
            check("done_load_stay", {31'd0, bus.Done}, 32'd1);
        end
        bus.Run = 1'b0;
        tick(1);
        check("done_clear", {31'd0, bus.Done}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_aval"},  {24'd0, bus.Aval},  32'h00);
        check({tag, "_bval"},  {24'd0, bus.Bval},  32'h00);
        check({tag, "_x"},     {31'd0, bus.X},     32'd0);
        check({tag, "_done"},  {31'd0, bus.Done},  32'd0);
        check({tag, "_sub"},   {31'd0, bus.Sub},   32'd0);
        check({tag, "_hold"},  {31'd0, bus.Hold},  32'd1);
        check({tag, "_add_a"}, {24'd0, bus.Add_A}, 32'h00);
        check({tag, "_add_b"}, {24'd0, bus.Add_B}, 32'h00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bus.Run          = 1'b0;
        bus.ClearA_LoadB = 1'b0;
        bus.S            = 8'h00;
        b_shadow         = 8'h00;
        tick(2);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(1);

        // 7 x -3 = -21
        load_b(8'hFD);
        run_op(8'h07, 0, 1'b0);

        // -128 x -128 = 16384, Sub in the final step only
        load_b(8'h80);
        run_op(8'h80, 1, 1'b0);

        // Zero multiplier: no active adds
        load_b(8'h00);
        run_op(8'h55, 0, 1'b0);

        // Run held through DONE, then B reloaded while parked in DONE
        load_b(8'h9C);
        run_op(8'hE3, 5, 1'b1);

        // Run and ClearA_LoadB together: load only, then start when load drops
        bus.S            = 8'h3C;
        bus.Run          = 1'b1;
        bus.ClearA_LoadB = 1'b1;
        tick(2);
        check("both_bval", {24'd0, bus.Bval}, 32'h3C);
        check("both_aval", {24'd0, bus.Aval}, 32'h00);
        check("both_done", {31'd0, bus.Done}, 32'd0);
        b_shadow = 8'h3C;
        run_op(8'hC5, 0, 1'b0);

        // Asynchronous abort during the fourth ADD
        load_b(8'hFF);
        bus.S   = 8'h11;
        bus.Run = 1'b1;
        tick(8);
        check("abort_precond_hold", {31'd0, bus.Hold}, 32'd0);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        bus.Run = 1'b0;
        tick(2);
        rst_n    = 1'b1;
        b_shadow = 8'h00;
        tick(20);
        check("abort_no_restart", {31'd0, bus.Done}, 32'd0);
        run_op(8'h6B, 0, 1'b0);

        // Randomized operations, sometimes chaining the previous low byte as B
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) != 0) load_b(8'($urandom));
            run_op(8'($urandom), $urandom_range(0, 3), 1'b0);
        end

        tick(3);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_control_unit.md
MULT_CONTROL_UNIT -- requirements
Module: mult_control_unit

Interface
REQ-001 Parameters: none; operand width fixed at 8 bits, adder result width fixed at 9 bits.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Run  input  1  level start request.
REQ-005 ClearA_LoadB  input  1  level request: load B from S, clear A and X.
REQ-006 S  input  8  switch operand (multiplicand and B load value).
REQ-007 Sum  input  9  result from downstream 8-bit add/subtract stage.
REQ-008 Add_A  output  8  adder operand A; equals register A.
REQ-009 Add_B  output  8  adder operand B; equals captured multiplicand M.
REQ-010 Sub  output  1  adder control_signal: 1 = A - M, 0 = A + M.
REQ-011 Hold  output  1  adder Continue: 1 forces adder operands to zero.
REQ-012 Aval  output  8  register A (product high byte).
REQ-013 Bval  output  8  register B (multiplier, then product low byte).
REQ-014 X  output  1  sign-extension bit of A.
REQ-015 Done  output  1  high while in DONE state.

Function
REQ-016 States SHALL be IDLE, START, ADD, SHIFT, DONE, with a 3-bit bit counter cnt.
REQ-017 In IDLE/DONE, ClearA_LoadB=1 SHALL load B<=S, A<=0, X<=0 on the next edge; ignored in all other states.
REQ-018 IDLE -> START when Run=1 and ClearA_LoadB=0; ClearA_LoadB has priority on simultaneous assertion.
REQ-019 START: M<=S, A<=0, X<=0, cnt<=0; -> ADD.
REQ-020 ADD: if B[0]=1 then A<=Sum[7:0], X<=Sum[8]; else A, X unchanged; -> SHIFT.
REQ-021 SHIFT: A<={X,A[7:1]}, B<={A[0],B[7:1]}, X unchanged; cnt<=cnt+1; -> ADD if cnt<7, else -> DONE (cnt wraps to 0).
REQ-022 Sub SHALL be 1 only in ADD with cnt=7 (two's-complement sign weight of multiplier); 0 otherwise.
REQ-023 Hold SHALL be 0 only in ADD with B[0]=1; 1 in every other state/condition.
REQ-024 DONE: Done=1; -> IDLE on the first edge with Run=0; Run held high SHALL NOT restart.
REQ-025 Latency: Run sampled high in IDLE on edge n -> DONE entered on edge n+17 (START 1, 8 x (ADD+SHIFT) 16).
REQ-026 Result: {A,B} SHALL equal signed 16-bit product of M and original B; X equals product sign.
REQ-027 S and ClearA_LoadB changes during START+1..DONE SHALL NOT affect the result.
REQ-028 Add_A, Add_B, Aval, Bval, X SHALL be direct register outputs; Sub, Hold, Done decoded from state only (no input paths).

Reset
REQ-029 Reset_n=0 SHALL immediately force state=IDLE, A=0, B=0, M=0, X=0, cnt=0, independent of Clk.
REQ-030 Reset output values: Aval=0, Bval=0, X=0, Done=0, Sub=0, Hold=1, Add_A=0, Add_B=0.
REQ-031 Reset asserted mid-operation SHALL abort; no partial result retained; operation resumes only on a new Run after Reset_n=1.

Verification
REQ-032 S=0xFD, ClearA_LoadB pulse; S=0x07, Run -> after 17 edges Done=1, Aval=0xFF, Bval=0xEB, X=1 (7 x -3 = -21).
REQ-033 B=0x80, S=0x80, Run -> Aval=0x40, Bval=0x00, X=0; Sub=1 observed exactly once, in final ADD.
REQ-034 B=0x00, S=0x55, Run -> Hold=1 every cycle, Aval=0x00, Bval=0x00, X=0.
REQ-035 Run held high through DONE for 5 cycles -> Done stays 1, no restart; Run=0 -> IDLE next edge, Done=0.
REQ-036 Reset_n low asynchronously during 4th ADD -> all outputs at REQ-030 values before next edge; state IDLE.
REQ-037 Run and ClearA_LoadB both high in IDLE -> B loaded, state stays IDLE; ClearA_LoadB low with Run high -> START next edge.
